// File: rtl/tinyqv_periph_bridge.sv
// Purpose: routes CPU non-memory transactions to NUM_CH peripheral channels with registered strobes.
// Latency: request sampled -> strobe next cycle; periph ready -> cpu_ready one cycle later (min 3 cycles total).
// Backpressure: waits on the selected channel's ready, gives up after TIMEOUT cycles with a bus error.
// Ports: cpu_* is the CPU data port (request held until cpu_ready pulses), periph_* carries the shared
//   addr/wdata plus per-channel strobes/ready/rdata, and bus_err/bus_err_clr is a sticky error flag and its clear.
module tinyqv_periph_bridge #(
  parameter int NUM_CH  = 4,
  parameter int CH_LSB  = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [27:0]          cpu_addr,
  input  logic [1:0]           cpu_write_n,
  input  logic [1:0]           cpu_read_n,
  input  logic [31:0]          cpu_wdata,
  output logic                 cpu_ready,
  output logic [31:0]          cpu_rdata,
  output logic [27:0]          periph_addr,
  output logic [31:0]          periph_wdata,
  output logic [2*NUM_CH-1:0]  periph_write_n,
  output logic [2*NUM_CH-1:0]  periph_read_n,
  input  logic [NUM_CH-1:0]    periph_ready,
  input  logic [32*NUM_CH-1:0] periph_rdata,
  output logic                 bus_err,
  input  logic                 bus_err_clr
);
  localparam int            CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);
  localparam logic [7:0]    CNT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [27:0]         addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          rtype_q, rtype_d;  // read size code; 11 means the access is a write
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [2*NUM_CH-1:0] wstb_q, wstb_d;
  logic [2*NUM_CH-1:0] rstb_q, rstb_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                err_q, err_d;

  logic            req_wr, req_rd, req, req_legal, set_err;
  logic [CH_W-1:0] req_idx;
  logic            sel_ready;
  logic [31:0]     sel_rdata, masked_rdata;

  assign req_wr    = (cpu_write_n != 2'b11);
  assign req_rd    = (cpu_read_n != 2'b11);
  assign req       = req_wr | req_rd;
  assign req_idx   = cpu_addr[CH_LSB +: CH_W];
  assign req_legal = ({1'b0, req_idx} < NUM_CH_L) && !(req_wr && req_rd);

  // Only the latched channel's ready/rdata matter; others are ignored.
  always_comb begin
    sel_ready = 1'b0;
    sel_rdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_q == CH_W'(i)) begin
        sel_ready = periph_ready[i];
        sel_rdata = periph_rdata[32*i +: 32];
      end
    end
  end

  always_comb begin
    case (rtype_q)
      2'b00:   masked_rdata = {24'b0, sel_rdata[7:0]};
      2'b01:   masked_rdata = {16'b0, sel_rdata[15:0]};
      2'b10:   masked_rdata = sel_rdata;
      default: masked_rdata = '0;  // writes return zero
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rtype_d = rtype_q;
    ch_d    = ch_q;
    cnt_d   = cnt_q;
    wstb_d  = wstb_q;
    rstb_d  = rstb_q;
    rdata_d = rdata_q;
    set_err = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          rtype_d = cpu_read_n;
          ch_d    = req_idx;
          cnt_d   = '0;
          if (req_legal) begin
            state_d = S_ACTIVE;
            for (int i = 0; i < NUM_CH; i++) begin
              if (req_idx == CH_W'(i)) begin
                wstb_d[2*i +: 2] = cpu_write_n;
                rstb_d[2*i +: 2] = cpu_read_n;
              end
            end
          end else begin
            // Bad channel or conflicting read+write: answer without touching any peripheral.
            state_d = S_DONE;
            rdata_d = '1;
            set_err = 1'b1;
          end
        end
      end
      S_ACTIVE: begin
        cnt_d = cnt_q + 8'd1;
        if (sel_ready) begin
          state_d = S_DONE;
          wstb_d  = '1;
          rstb_d  = '1;
          rdata_d = masked_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          wstb_d  = '1;
          rstb_d  = '1;
          rdata_d = '1;
          set_err = 1'b1;
        end
      end
      S_DONE: begin
        // cpu_ready is high this cycle; clear data so cpu_rdata idles at zero.
        state_d = S_IDLE;
        cnt_d   = '0;
        rdata_d = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new error takes priority over a coincident clear.
  assign err_d = set_err ? 1'b1 : (bus_err_clr ? 1'b0 : err_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      rtype_q <= 2'b11;
      ch_q    <= '0;
      cnt_q   <= '0;
      wstb_q  <= '1;
      rstb_q  <= '1;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rtype_q <= rtype_d;
      ch_q    <= ch_d;
      cnt_q   <= cnt_d;
      wstb_q  <= wstb_d;
      rstb_q  <= rstb_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign cpu_ready      = (state_q == S_DONE);
  assign cpu_rdata      = rdata_q;
  assign periph_addr    = addr_q;
  assign periph_wdata   = wdata_q;
  assign periph_write_n = wstb_q;
  assign periph_read_n  = rstb_q;
  assign bus_err        = err_q;

endmodule

// File: tb/tb_tinyqv_periph_bridge.sv
// Directed bench for tinyqv_periph_bridge: a 4-channel and a 3-channel instance.
// Expected completions are queued when a request is driven and popped on cpu_ready.
module tb_tinyqv_periph_bridge;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rstn;
  logic bus_err_clr;

  logic [27:0]  a4;  logic [1:0] w4, r4;  logic [31:0] wd4;
  logic         rdy4; logic [31:0] rd4; logic [27:0] pa4; logic [31:0] pw4;
  logic [7:0]   pwn4, prn4; logic [3:0] pr4; logic [127:0] prd4; logic be4;

  logic [27:0]  a3;  logic [1:0] w3, r3;  logic [31:0] wd3;
  logic         rdy3; logic [31:0] rd3; logic [27:0] pa3; logic [31:0] pw3;
  logic [5:0]   pwn3, prn3; logic [2:0] pr3; logic [95:0] prd3; logic be3;

  tinyqv_periph_bridge #(.NUM_CH(4), .CH_LSB(8), .TIMEOUT(15)) u_dut4 (
    .clk(clk), .rstn(rstn), .cpu_addr(a4), .cpu_write_n(w4), .cpu_read_n(r4), .cpu_wdata(wd4),
    .cpu_ready(rdy4), .cpu_rdata(rd4), .periph_addr(pa4), .periph_wdata(pw4),
    .periph_write_n(pwn4), .periph_read_n(prn4), .periph_ready(pr4), .periph_rdata(prd4),
    .bus_err(be4), .bus_err_clr(bus_err_clr));

  tinyqv_periph_bridge #(.NUM_CH(3), .CH_LSB(8), .TIMEOUT(15)) u_dut3 (
    .clk(clk), .rstn(rstn), .cpu_addr(a3), .cpu_write_n(w3), .cpu_read_n(r3), .cpu_wdata(wd3),
    .cpu_ready(rdy3), .cpu_rdata(rd3), .periph_addr(pa3), .periph_wdata(pw3),
    .periph_write_n(pwn3), .periph_read_n(prn3), .periph_ready(pr3), .periph_rdata(prd3),
    .bus_err(be3), .bus_err_clr(bus_err_clr));

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic err4_m = 1'b0;
  logic err3_m = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic cur_rdy(input bit u3);
    return u3 ? rdy3 : rdy4;
  endfunction
  function automatic logic [31:0] cur_rd(input bit u3);
    return u3 ? rd3 : rd4;
  endfunction
  function automatic logic cur_be(input bit u3);
    return u3 ? be3 : be4;
  endfunction
  function automatic logic [7:0] cur_w(input bit u3);
    return u3 ? {2'b11, pwn3} : pwn4;
  endfunction
  function automatic logic [7:0] cur_r(input bit u3);
    return u3 ? {2'b11, prn3} : prn4;
  endfunction
  function automatic logic [27:0] cur_pa(input bit u3);
    return u3 ? pa3 : pa4;
  endfunction
  function automatic logic [31:0] cur_pw(input bit u3);
    return u3 ? pw3 : pw4;
  endfunction

  task automatic drive_req(input bit u3, input logic [27:0] addr, input logic [1:0] wr, input logic [1:0] rd,
                           input logic [31:0] wd);
    if (u3) begin a3 = addr; w3 = wr; r3 = rd; wd3 = wd; end
    else    begin a4 = addr; w4 = wr; r4 = rd; wd4 = wd; end
  endtask

  // rdy_at: ACTIVE cycle (1-based) in which ready is raised, 0 = never.
  // exp_lat: cycle of cpu_ready counting the request cycle as cycle 1.
  task automatic txn(input string tag, input bit u3, input logic [27:0] addr, input logic [1:0] wr,
                     input logic [1:0] rd, input logic [31:0] wd, input int rdy_ch, input int rdy_at,
                     input bit clr, input logic [7:0] exp_w, input logic [7:0] exp_r, input int exp_lat,
                     input logic [31:0] exp_d, input logic exp_e);
    int   cyc;
    bit   seen;
    bit   clr_pend;
    int   nch;
    exp_t e;
    nch = u3 ? 3 : 4;
    drive_req(u3, addr, wr, rd, wd);
    bus_err_clr = clr;
    clr_pend = clr;
    e.err = exp_e;
    e.rdata = exp_d;
    sb.push_back(e);
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      step();
      cyc++;
      pr4 = '0;
      pr3 = '0;
      if (clr_pend) begin
        bus_err_clr = 1'b0;
        clr_pend = 1'b0;
        err4_m = 1'b0;
        err3_m = 1'b0;
      end
      if (cur_rdy(u3)) begin
        seen = 1'b1;
        chk({tag, " latency"}, cyc, exp_lat);
        chk({tag, " sb_size"}, sb.size(), 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk({tag, " rdata"}, cur_rd(u3), e.rdata);
          if (u3) err3_m = err3_m | e.err;
          else    err4_m = err4_m | e.err;
          chk({tag, " bus_err"}, cur_be(u3), u3 ? err3_m : err4_m);
        end
        chk({tag, " strobes_done"}, {cur_w(u3), cur_r(u3)}, 16'hFFFF);
      end else begin
        chk({tag, " wstb"}, cur_w(u3), exp_w);
        chk({tag, " rstb"}, cur_r(u3), exp_r);
        chk({tag, " paddr"}, cur_pa(u3), addr);
        chk({tag, " pwdata"}, cur_pw(u3), wd);
        if (rdy_at != 0 && cyc - 1 == rdy_at) begin
          if (u3) pr3[rdy_ch] = 1'b1; else pr4[rdy_ch] = 1'b1;
        end else if (rdy_at != 1 && cyc - 1 == 1) begin
          // ready from a channel that was not addressed must not complete the access
          if (u3) pr3[(rdy_ch + 1) % nch] = 1'b1; else pr4[(rdy_ch + 1) % nch] = 1'b1;
        end
      end
    end
    chk({tag, " completed"}, 32'(seen), 32'd1);
    if (!seen && sb.size() > 0) void'(sb.pop_front());
    drive_req(u3, 28'h0, 2'b11, 2'b11, 32'h0);
    step();
    chk({tag, " ready_pulse_end"}, 32'(cur_rdy(u3)), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    bus_err_clr = 1'b0;
    drive_req(1'b0, 28'h0, 2'b11, 2'b11, 32'h0);
    drive_req(1'b1, 28'h0, 2'b11, 2'b11, 32'h0);
    pr4 = '0;
    pr3 = '0;
    prd4 = {32'h5555_AAAA, 32'h1234_5678, 32'hAABB_CCDD, 32'h0BAD_F00D};
    prd3 = {32'hCAFE_F00D, 32'h1122_3344, 32'h9988_7766};
    #12;
    chk("reset cpu_ready", 32'(rdy4), 32'd0);
    chk("reset cpu_rdata", rd4, 32'h0);
    chk("reset periph_addr", pa4, 32'h0);
    chk("reset periph_wdata", pw4, 32'h0);
    chk("reset write_n", pwn4, 8'hFF);
    chk("reset read_n", prn4, 8'hFF);
    chk("reset bus_err", 32'(be4), 32'd0);
    chk("reset d3 strobes", {pwn3, prn3}, 12'hFFF);
    @(negedge clk);
    rstn = 1'b1;
    step();

    txn("rd32_ch2", 1'b0, 28'h200_0200, 2'b11, 2'b10, 32'h0,        2, 1, 1'b0, 8'hFF, 8'hEF, 3,  32'h1234_5678, 1'b0);
    txn("rd8_ch1",  1'b0, 28'h200_0100, 2'b11, 2'b00, 32'h0,        1, 1, 1'b0, 8'hFF, 8'hF3, 3,  32'h0000_00DD, 1'b0);
    txn("rd16_ch1", 1'b0, 28'h200_0100, 2'b11, 2'b01, 32'h0,        1, 2, 1'b0, 8'hFF, 8'hF7, 4,  32'h0000_CCDD, 1'b0);
    txn("wr32_ch0", 1'b0, 28'h200_0000, 2'b10, 2'b11, 32'hDEAD_BEEF, 0, 4, 1'b0, 8'hFE, 8'hFF, 6,  32'h0,         1'b0);
    txn("tmo_ch3",  1'b0, 28'h200_0300, 2'b11, 2'b10, 32'h0,        3, 0, 1'b0, 8'hFF, 8'hBF, 17, 32'hFFFF_FFFF, 1'b1);

    bus_err_clr = 1'b1;
    step();
    bus_err_clr = 1'b0;
    err4_m = 1'b0;
    err3_m = 1'b0;
    chk("clr bus_err", 32'(be4), 32'(err4_m));

    txn("rdwr_clr_same", 1'b0, 28'h200_0000, 2'b10, 2'b10, 32'h0,   0, 0, 1'b1, 8'hFF, 8'hFF, 2,  32'hFFFF_FFFF, 1'b1);
    txn("d3_idx3",      1'b1, 28'h200_0300, 2'b11, 2'b10, 32'h0,   0, 0, 1'b0, 8'hFF, 8'hFF, 2,  32'hFFFF_FFFF, 1'b1);
    txn("d3_rdwr",      1'b1, 28'h200_0100, 2'b00, 2'b00, 32'h77,  0, 0, 1'b0, 8'hFF, 8'hFF, 2,  32'hFFFF_FFFF, 1'b1);
    txn("d3_rd32_ch2",  1'b1, 28'h200_0200, 2'b11, 2'b10, 32'h0,   2, 1, 1'b0, 8'hFF, 8'hEF, 3,  32'hCAFE_F00D, 1'b0);

    // Reset in the middle of an ACTIVE transaction.
    drive_req(1'b0, 28'h200_0100, 2'b11, 2'b00, 32'h0);
    step();
    chk("rst_mid pre strobe", prn4, 8'hF3);
    #3;
    rstn = 1'b0;
    #1;
    chk("rst_mid async read_n", prn4, 8'hFF);
    chk("rst_mid cpu_ready", 32'(rdy4), 32'd0);
    chk("rst_mid bus_err", 32'(be4), 32'd0);
    drive_req(1'b0, 28'h0, 2'b11, 2'b11, 32'h0);
    err4_m = 1'b0;
    err3_m = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rst_hold cpu_ready", 32'(rdy4), 32'd0);
    end
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_after cpu_ready", 32'(rdy4), 32'd0);
      chk("rst_after strobes", {pwn4, prn4}, 16'hFFFF);
    end
    chk("sb drained", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
